// File: rtl/sync_fifo_axis.sv
// Single-clock AXI-Stream FIFO with a first-word fall-through output register, tlast and fill level.
// Define SYNC_FIFO_AXIS_PKT_MODE_EN to hold output until a whole frame is stored.
module sync_fifo_axis #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 512,
  parameter int AFULL_THRESH = DEPTH - 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_LVL = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] ONE_LVL    = LW'(1);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  s_ready_q;
  logic                  afull_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  m_valid;
  logic                  wr_en, rd_en, ram_wr, ram_rd, bypass;

`ifdef SYNC_FIFO_AXIS_PKT_MODE_EN
  logic [LW-1:0] pkt_q, pkt_d;

  // A full FIFO must stream even without a stored tlast, or an oversize frame deadlocks.
  assign m_valid = (level_q != '0) && ((pkt_q != '0) || (level_q == FULL_LVL));

  always_comb begin
    pkt_d = pkt_q;
    if ((wr_en && s_axis_tlast) && !(rd_en && out_last_q))      pkt_d = pkt_q + ONE_LVL;
    else if (!(wr_en && s_axis_tlast) && (rd_en && out_last_q)) pkt_d = pkt_q - ONE_LVL;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) pkt_q <= '0;
    else          pkt_q <= pkt_d;
  end
`else
  assign m_valid = (level_q != '0);
`endif

  assign wr_en  = s_axis_tvalid && s_ready_q;
  assign rd_en  = m_valid && m_axis_tready;
  // The output register always holds the head beat, so the RAM holds level-1 beats.
  assign ram_rd = rd_en && (level_q > ONE_LVL);
  assign bypass = wr_en && ((level_q == '0) || (rd_en && (level_q == ONE_LVL)));
  assign ram_wr = wr_en && !bypass;

  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_en)      level_d = level_q + ONE_LVL;
    else if (!wr_en && rd_en) level_d = level_q - ONE_LVL;
  end

  // NOTE: the storage array has no reset; pointers and level make stale contents unreachable.
  always_ff @(posedge aclk) begin
    if (ram_wr) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      s_ready_q  <= 1'b0;
      afull_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (ram_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ram_rd) begin
        rd_ptr_q                 <= rd_ptr_q + 1'b1;
        {out_last_q, out_data_q} <= mem[rd_ptr_q];
      end else if (bypass) begin
        {out_last_q, out_data_q} <= {s_axis_tlast, s_axis_tdata};
      end
      level_q   <= level_d;
      s_ready_q <= (level_d != FULL_LVL);
      afull_q   <= (level_d >= THRESH_LVL);
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign level         = level_q;
  assign almost_full   = afull_q;

endmodule

// File: tb/tb_sync_fifo_axis.sv
// Self-checking bench for sync_fifo_axis: directed and random traffic against a queue model.
// Expectations follow SYNC_FIFO_AXIS_PKT_MODE_EN when it is defined for the build.
module tb_sync_fifo_axis;

  localparam int DW     = 32;
  localparam int DEPTH  = 8;
  localparam int THRESH = 6;
  localparam int LW     = $clog2(DEPTH) + 1;
`ifdef SYNC_FIFO_AXIS_PKT_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic [LW-1:0] level;
  logic          almost_full;

  sync_fifo_axis #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(THRESH)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .level        (level),
    .almost_full  (almost_full)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {tlast, tdata} beats held, frames held, and the registered ready.
  logic [DW:0] q[$];
  int          pkt = 0;
  bit          exp_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_valid();
    if (q.size() == 0) return 1'b0;
    if (PKT) return (pkt > 0) || (q.size() == DEPTH);
    return 1'b1;
  endfunction

  // One clock: check outputs at the falling edge, drive inputs, apply the transfer rules at the rising edge.
  task automatic step(input bit iv, input logic [DW-1:0] id, input bit il, input bit ordy,
                      input string tag, output bit acc);
    bit exp_v;
    bit rd;
    exp_v = model_valid();
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'(exp_v));
    if (exp_v) begin
      check({tag, "_tdata"}, 64'(m_tdata), 64'(q[0][DW-1:0]));
      check({tag, "_tlast"}, 64'(m_tlast), 64'(q[0][DW]));
    end
    check({tag, "_level"}, 64'(level), 64'(q.size()));
    check({tag, "_tready"}, 64'(s_tready), 64'(exp_ready));
    check({tag, "_afull"}, 64'(almost_full), 64'(q.size() >= THRESH));
    s_tvalid = iv;
    s_tdata  = id;
    s_tlast  = il;
    m_tready = ordy;
    acc = iv && exp_ready;
    rd  = exp_v && ordy;
    @(posedge aclk);
    if (rd) begin
      if (q[0][DW]) pkt--;
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back({il, id});
      if (il) pkt++;
    end
    exp_ready = (q.size() != DEPTH);
    @(negedge aclk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rst_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_rst_tdata"}, 64'(m_tdata), 64'd0);
    check({tag, "_rst_tlast"}, 64'(m_tlast), 64'd0);
    check({tag, "_rst_level"}, 64'(level), 64'd0);
    check({tag, "_rst_tready"}, 64'(s_tready), 64'd0);
    check({tag, "_rst_afull"}, 64'(almost_full), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int sent;

    // Power-on reset.
    #1;
    reset_checks("por");
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    step(0, '0, 0, 0, "idle", acc);
    check("post_reset_tready", 64'(s_tready), 64'd1);

    // Single beat into an empty FIFO appears the next cycle, then drains.
    step(1, 32'hA5A5_A5A5, 1, 0, "single_wr", acc);
    check("single_tvalid", 64'(m_tvalid), 64'd1);
    check("single_tdata", 64'(m_tdata), 64'hA5A5_A5A5);
    check("single_level", 64'(level), 64'd1);
    step(0, '0, 0, 1, "single_rd", acc);
    check("single_level_after", 64'(level), 64'd0);

    // Fill with the sink stalled, attempt one write while full, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), i == DEPTH - 1, 0, "fill", acc);
    check("fill_tready", 64'(s_tready), 64'd0);
    check("fill_level", 64'(level), 64'(DEPTH));
    check("fill_afull", 64'(almost_full), 64'd1);
    step(1, 32'hDEAD_BEEF, 1, 0, "full_reject", acc);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 64'(m_tdata), 64'(i));
      step(0, '0, 0, 1, "drain", acc);
    end
    check("drain_level", 64'(level), 64'd0);

    // Continuous streaming, one beat per cycle in and out.
    for (int i = 0; i < 100; i++) begin
      step(1, 32'h1000 + DW'(i), 1, 1, "stream", acc);
      check("stream_accept", 64'(acc), 64'd1);
      check("stream_level", 64'(level), 64'd1);
    end
    step(0, '0, 0, 1, "stream_end", acc);

    // Random valid/ready at 50 % with random frame boundaries.
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      step($urandom_range(1, 0) == 1, $urandom(), ($urandom_range(3, 0) == 0) || (sent == 999),
           $urandom_range(1, 0) == 1, "rand", acc);
      if (acc) sent++;
    end
    check("rand_sent", 64'(sent), 64'd1000);
    for (int c = 0; c < 400 && q.size() > 0; c++)
      step(0, '0, 0, $urandom_range(1, 0) == 1, "rand_drain", acc);
    check("rand_drain_level", 64'(level), 64'd0);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 5; i++) step(1, 32'h2000 + DW'(i), 0, 0, "pre_rst", acc);
    check("pre_rst_level", 64'(level), 64'd5);
    #2;
    aresetn = 1'b0;
    s_tvalid = 1'b0;
    q.delete();
    pkt = 0;
    exp_ready = 1'b0;
    #1;
    reset_checks("mid");
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, "post_rst", acc);
    check("post_rst_tready", 64'(s_tready), 64'd1);
    check("post_rst_tvalid", 64'(m_tvalid), 64'd0);

    // Short frame: in packet mode the output waits for its tlast beat.
    for (int i = 0; i < 3; i++) step(1, 32'h3000 + DW'(i), i == 2, 1, "frame3", acc);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, "frame3_out", acc);
    check("frame3_level", 64'(level), 64'd0);

    // Frame longer than DEPTH: tlast only on beat 10, so packet mode relies on the full release.
    sent = 0;
    for (int c = 0; c < 80 && (sent < 10 || q.size() > 0); c++) begin
      step(sent < 10, 32'h4000 + DW'(sent), sent == 9, 1, "long", acc);
      if (acc) sent++;
    end
    check("long_sent", 64'(sent), 64'd10);
    check("long_level", 64'(level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
